vga_fb_reader: RTL and testbench

- Parametrised frame-buffer readout stage between the VGA timing generator and multi-bank image RAM.
- Maps raster coordinates inside a configurable display window to a bank-local RAM address.
- Selects one of NBANKS RAM data buses and compensates RAM read latency so that pixel data, window flag and blanking stay aligned.
- Adds frame-synchronous 2x zoom and a border colour.

---
 rtl/vga_fb_reader.sv | 147 ++++++++++++++
 tb/tb_vga_fb_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_reader
// Purpose  : Frame-buffer readout between the VGA timing generator and a
//            multi-bank image RAM. It maps raster coordinates inside a display
//            window to a bank-local read address, selects the addressed bank's
//            data bus, and compensates RAM read latency. Frame-synchronous 2x
//            zoom and a border colour outside the window are also provided.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            videoon          - active-video flag
//            pixel_x/pixel_y  - raster coordinates
//            zoom_req         - requested zoom (0 = 1x, 1 = 2x), taken at (0,0)
//            border_color     - colour for active video outside the window
//            din              - NBANKS concatenated RAM data buses
//            addr             - bank-local RAM read address (1 clock latency)
//            dout/dout_valid  - output pixel and window flag (RD_LAT+1 clocks)
//            zoom_active      - zoom mode currently in effect
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_reader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 17,
  parameter int PIX_W     = 11,
  parameter int X_BEGIN   = 1,
  parameter int Y_BEGIN   = 1,
  parameter int IM_W      = 320,
  parameter int IM_H      = 280,
  parameter int NBANKS    = 2,
  parameter int BANK_ROWS = 280,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     videoon,
  input  logic [PIX_W-1:0]         pixel_x,
  input  logic [PIX_W-1:0]         pixel_y,
  input  logic                     zoom_req,
  input  logic [DATA_W-1:0]        border_color,
  input  logic [NBANKS*DATA_W-1:0] din,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     zoom_active
);

  // Two spare bits keep the window end (begin + doubled size) from wrapping.
  localparam int CW     = PIX_W + 2;
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int MW     = ADDR_W + CW;
  localparam int PW     = BANK_W + 2;

  logic [CW-1:0]     px, py, x_lo, y_lo, x_hi, y_hi, col, row, lrow;
  logic              hit;
  logic [BANK_W-1:0] bank;
  logic [PW-1:0]     pipe [0:RD_LAT];   // {videoon, hit, bank} per stage
  logic              d_vo, d_hit;
  logic [BANK_W-1:0] d_bank;
  logic [DATA_W-1:0] din_sel;

  assign px   = CW'(pixel_x);
  assign py   = CW'(pixel_y);
  assign x_lo = CW'(X_BEGIN);
  assign y_lo = CW'(Y_BEGIN);
  assign x_hi = x_lo + (CW'(IM_W) << zoom_active);
  assign y_hi = y_lo + (CW'(IM_H) << zoom_active);

  assign hit = videoon && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

  // Outside the window these subtractions may wrap; they are only used on a hit.
  assign col = (px - x_lo) >> zoom_active;
  assign row = (py - y_lo) >> zoom_active;

  // Bank decode by comparator chain: the highest threshold passed wins.
  always_comb begin
    bank = '0;
    lrow = row;
    for (int b = 1; b < NBANKS; b++) begin
      if (row >= CW'(b * BANK_ROWS)) begin
        bank = BANK_W'(b);
        lrow = row - CW'(b * BANK_ROWS);
      end
    end
  end

  // Frame-start zoom latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      zoom_active <= 1'b0;
    end else if (pixel_x == '0 && pixel_y == '0) begin
      zoom_active <= zoom_req;
    end
  end

  // Stage 0: address generation; address holds while outside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      pipe[0] <= '0;
    end else begin
      pipe[0] <= {videoon, hit, bank};
      if (hit) begin
        addr <= ADDR_W'(MW'(col) + MW'(lrow) * MW'(IM_W));
      end
    end
  end

  // Latency-matching delay line, one stage per RAM read-latency clock.
  for (genvar i = 1; i <= RD_LAT; i++) begin : g_dly
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe[i] <= '0;
      end else begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {d_vo, d_hit, d_bank} = pipe[RD_LAT];

  always_comb begin
    din_sel = din[DATA_W-1:0];
    for (int b = 1; b < NBANKS; b++) begin
      if (d_bank == BANK_W'(b)) begin
        din_sel = din[b*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage; border colour is taken live here, not pipelined.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (d_hit) begin
      dout       <= din_sel;
      dout_valid <= 1'b1;
    end else if (d_vo) begin
      dout       <= border_color;
      dout_valid <= 1'b0;
    end else begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_reader
// Purpose  : Directed self-checking bench for vga_fb_reader. Three instances
//            (RD_LAT = 1, 0, 3) share the raster inputs; each has its own
//            RAM model whose word is a simple function of bank and address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        videoon;
  logic [10:0] pixel_x, pixel_y;
  logic        zoom_req;
  logic [15:0] border_color;

  logic [31:0] din0, din1, din3, d3a, d3b;
  logic [16:0] addr0, addr1, addr3;
  logic [15:0] dout0, dout1, dout3;
  logic        val0, val1, val3, zm0, zm1, zm3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic b, input logic [16:0] a);
    logic [15:0] base;
    base = b ? 16'h8000 : 16'h1000;
    return base + a[15:0];
  endfunction

  assign din0 = {ram_word(1'b1, addr0), ram_word(1'b0, addr0)};
  always @(posedge clk) begin
    din1 <= {ram_word(1'b1, addr1), ram_word(1'b0, addr1)};
    d3a  <= {ram_word(1'b1, addr3), ram_word(1'b0, addr3)};
    d3b  <= d3a;
    din3 <= d3b;
  end

  vga_fb_reader #(.BANK_ROWS(140), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .videoon(videoon), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .zoom_req(zoom_req), .border_color(border_color), .din(din1),
    .addr(addr1), .dout(dout1), .dout_valid(val1), .zoom_active(zm1));

  vga_fb_reader #(.BANK_ROWS(140), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .videoon(videoon), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .zoom_req(zoom_req), .border_color(border_color), .din(din0),
    .addr(addr0), .dout(dout0), .dout_valid(val0), .zoom_active(zm0));

  vga_fb_reader #(.BANK_ROWS(140), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .videoon(videoon), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .zoom_req(zoom_req), .border_color(border_color), .din(din3),
    .addr(addr3), .dout(dout3), .dout_valid(val3), .zoom_active(zm3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one coordinate for one clock, then settle 1 ns past the edge.
  task automatic tick(input int x, input int y, input logic vo);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    videoon = vo;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; zoom_req = 1'b0; border_color = 16'hF800;
    videoon = 1'b0; pixel_x = '0; pixel_y = '0;
    tick(5, 5, 1'b0);
    tick(5, 5, 1'b1);
    chk("reset_addr",  32'(addr1), 32'd0);
    chk("reset_dout",  32'(dout1), 32'd0);
    chk("reset_valid", 32'(val1),  32'd0);
    chk("reset_zoom",  32'(zm1),   32'd0);
    rst = 1'b0;

    // First line, window edges
    tick(1, 1, 1'b1);     chk("addr_1_1",     32'(addr1), 32'd0);
    tick(320, 1, 1'b1);   chk("addr_320_1",   32'(addr1), 32'd319);
    tick(321, 1, 1'b1);   chk("addr_hold",    32'(addr1), 32'd319);
                          chk("dout_1_1",     32'(dout1), 32'h1000);
                          chk("valid_1_1",    32'(val1),  32'd1);
    tick(1, 2, 1'b1);     chk("addr_1_2",     32'(addr1), 32'd320);
                          chk("dout_320_1",   32'(dout1), 32'h113F);
    tick(0, 2, 1'b0);     chk("border_dout",  32'(dout1), 32'hF800);
                          chk("border_valid", 32'(val1),  32'd0);
    tick(0, 2, 1'b0);     chk("dout_1_2",     32'(dout1), 32'h1140);
    tick(0, 2, 1'b0);     chk("blank_dout",   32'(dout1), 32'd0);

    // Bank switch at row 140
    tick(1, 140, 1'b1);   chk("addr_bank0_last", 32'(addr1), 32'd44480);
    tick(1, 141, 1'b1);   chk("addr_bank1_first", 32'(addr1), 32'd0);
    tick(0, 141, 1'b0);   chk("dout_bank0_last", 32'(dout1), 32'hBDC0);
    tick(0, 141, 1'b0);   chk("dout_bank1_first", 32'(dout1), 32'h8000);
                          chk("valid_bank1",  32'(val1),  32'd1);

    // Last window row and the row below it
    tick(320, 280, 1'b1); chk("addr_last_px", 32'(addr1), 32'd44799);
    tick(320, 281, 1'b1); chk("addr_below_hold", 32'(addr1), 32'd44799);
    tick(0, 281, 1'b0);   chk("dout_last_px", 32'(dout1), 32'h2EFF);
    tick(0, 281, 1'b0);   chk("dout_below",   32'(dout1), 32'hF800);
                          chk("valid_below",  32'(val1),  32'd0);

    // Zoom takes effect only at frame start
    zoom_req = 1'b1;
    tick(5, 5, 1'b1);     chk("zoom_midframe", 32'(zm1), 32'd0);
    tick(0, 0, 1'b0);     chk("zoom_framestart", 32'(zm1), 32'd1);
    tick(5, 1, 1'b1);     chk("zaddr_5_1",    32'(addr1), 32'd2);
    tick(2, 1, 1'b1);     chk("zaddr_2_1",    32'(addr1), 32'd0);
    tick(3, 3, 1'b1);     chk("zaddr_3_3",    32'(addr1), 32'd321);
    tick(640, 1, 1'b1);   chk("zaddr_640_1",  32'(addr1), 32'd319);
    tick(641, 1, 1'b1);   chk("zaddr_641_hold", 32'(addr1), 32'd319);
    tick(0, 1, 1'b0);     chk("zdout_640",    32'(dout1), 32'h113F);
                          chk("zvalid_640",   32'(val1),  32'd1);
    tick(0, 1, 1'b0);     chk("zdout_641",    32'(dout1), 32'hF800);
                          chk("zvalid_641",   32'(val1),  32'd0);
    zoom_req = 1'b0;
    tick(7, 7, 1'b1);     chk("zoom_hold",    32'(zm1), 32'd1);
    tick(0, 0, 1'b0);     chk("zoom_off",     32'(zm1), 32'd0);

    // videoon low inside the window
    tick(10, 10, 1'b1);
    tick(10, 10, 1'b0);
    tick(11, 10, 0);      chk("dout_10_10",   32'(dout1), 32'h1B49);
    tick(11, 10, 1'b0);   chk("vo0_dout",     32'(dout1), 32'd0);
                          chk("vo0_valid",    32'(val1),  32'd0);

    // Reset in the middle of a line
    tick(99, 50, 1'b1);
    tick(100, 50, 1'b1);
    rst = 1'b1;
    tick(100, 50, 1'b1);  chk("mrst_addr",    32'(addr1), 32'd0);
                          chk("mrst_dout",    32'(dout1), 32'd0);
                          chk("mrst_valid",   32'(val1),  32'd0);
    rst = 1'b0;
    tick(101, 50, 1'b1);  chk("post_rst_addr", 32'(addr1), 32'd15780);
                          chk("post_rst_valid", 32'(val1), 32'd0);
    tick(102, 50, 1'b1);
    tick(0, 50, 1'b0);    chk("post_rst_dout", 32'(dout1), 32'h4DA4);

    // Latency sweep: x=1..8 on row 1 reads bank0 address x-1
    for (int s = 0; s < 12; s++) begin
      if (s < 8) tick(s + 1, 1, 1'b1);
      else       tick(0, 1, 1'b0);
      if (s >= 1 && s <= 8) begin
        chk("lat0_dout",  32'(dout0), 32'(16'h1000 + 16'(s - 1)));
        chk("lat0_valid", 32'(val0),  32'd1);
      end
      if (s >= 4 && s <= 11) begin
        chk("lat3_dout",  32'(dout3), 32'(16'h1000 + 16'(s - 4)));
        chk("lat3_valid", 32'(val3),  32'd1);
      end
    end
    chk("lat0_after", 32'(val0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
